// File: rtl/down_counter_pkg.sv
// Shared types for the loadable down-counter/timer.
// The state encoding is fixed at two bits so it stays stable in waveforms and debug dumps.
package down_counter_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } state_t;

endpackage

// File: rtl/down_counter_tick_prescaler.sv
// Divides enabled cycles into one tick every PRESCALE cycles for the down-counter.
// With PRESCALE==1 the tick is just the enable, so no register is built.
import down_counter_pkg::*;

module tick_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_tick
);

  generate
    if (PRESCALE <= 1) begin : g_direct
      logic w_unused;
      assign w_unused = clock ^ reset ^ i_clear;
      assign o_tick   = i_enable;
    end else begin : g_divided
      localparam int CW = $clog2(PRESCALE);
      logic [CW-1:0] r_phase;
      logic          w_last;

      assign w_last = (r_phase == CW'(PRESCALE - 1));
      assign o_tick = i_enable && w_last;

      // The phase only advances on enabled cycles, so a pause freezes it in place.
      always_ff @(posedge clock) begin
        if (reset) begin
          r_phase <= '0;
        end else if (i_clear) begin
          r_phase <= '0;
        end else if (i_enable) begin
          if (w_last) begin
            r_phase <= '0;
          end else begin
            r_phase <= r_phase + CW'(1);
          end
        end
      end
    end
  endgenerate

endmodule

// File: rtl/down_counter.sv
// Loadable, pausable down-counter/timer with a one-cycle done pulse at terminal count.
// Define DOWN_COUNTER_AUTO_RELOAD_EN to make it a periodic timer that reloads on terminal.
import down_counter_pkg::*;

module down_counter #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_value,
  input  logic             i_start,
  input  logic             i_pause,
  output logic [WIDTH-1:0] o_count,
  output logic             o_busy,
  output logic             o_zero,
  output logic             o_done
);

  state_t           r_state;
  state_t           w_nextState;
  logic [WIDTH-1:0] r_count;
  logic             r_done;
  logic             w_countIsZero;
  logic             w_startAccepted;
  logic             w_prescClear;
  logic             w_prescEnable;
  logic             w_tick;
  logic             w_terminal;
  logic             w_reloadValid;
  logic [WIDTH-1:0] w_reloadValue;

  assign w_countIsZero   = (r_count == '0);
  assign w_startAccepted = (r_state == IDLE) && i_start && !i_pause && !i_load;
  assign w_prescClear    = i_load || w_startAccepted;
  // A paused timer whose pause just dropped resumes counting on that same edge,
  // so the delay added equals exactly the number of cycles pause was held.
  assign w_prescEnable   = (r_state != IDLE) && !i_pause && !i_load;
  assign w_terminal      = w_tick && (r_count == WIDTH'(1));

`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
  logic [WIDTH-1:0] r_reload;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_reload <= '0;
    end else if (i_load) begin
      r_reload <= i_load_value;
    end
  end

  assign w_reloadValue = r_reload;
  assign w_reloadValid = (r_reload != '0);
`else
  assign w_reloadValue = '0;
  assign w_reloadValid = 1'b0;
`endif

  tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clock    (clock),
    .reset    (reset),
    .i_clear  (w_prescClear),
    .i_enable (w_prescEnable),
    .o_tick   (w_tick)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    if (i_load) begin
      w_nextState = IDLE;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_startAccepted && !w_countIsZero) begin
            w_nextState = RUN;
          end
        end
        RUN, PAUSED: begin
          if (i_pause) begin
            w_nextState = PAUSED;
          end else if (w_terminal && !w_reloadValid) begin
            w_nextState = IDLE;
          end else begin
            w_nextState = RUN;
          end
        end
        default: w_nextState = IDLE;
      endcase
    end
  end

  // Count never drops below zero: the terminal tick lands on 0 (or the reload value).
  always_ff @(posedge clock) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_value;
    end else if (w_tick) begin
      if (w_terminal) begin
        r_count <= w_reloadValid ? w_reloadValue : '0;
      end else begin
        r_count <= r_count - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset || i_load) begin
      r_done <= 1'b0;
    end else begin
      r_done <= w_terminal || (w_startAccepted && w_countIsZero);
    end
  end

  always_comb begin
    o_count = r_count;
    o_busy  = (r_state != IDLE);
    o_zero  = w_countIsZero;
    o_done  = r_done;
  end

endmodule
